// File: rtl/sifive_insight_tl_a_capture.sv
// TileLink A-channel snoop capture: beat tracking plus a record FIFO with drop counting.
// Define SIFIVE_INSIGHT_TL_A_DATA_CAPTURE_EN to also store and output a_data/a_mask per record.
module sifive_insight_tl_a_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       a_valid,
  input  logic                       a_ready,
  input  logic [2:0]                 a_opcode,
  input  logic [2:0]                 a_param,
  input  logic [SIZE_W-1:0]          a_size,
  input  logic                       a_source,
  input  logic [ADDR_W-1:0]          a_address,
  input  logic [DATA_W/8-1:0]        a_mask,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       a_corrupt,
  output logic                       rec_valid,
  output logic [2:0]                 rec_opcode,
  output logic [2:0]                 rec_param,
  output logic [SIZE_W-1:0]          rec_size,
  output logic                       rec_source,
  output logic [ADDR_W-1:0]          rec_address,
  output logic [DATA_W/8-1:0]        rec_mask,
  output logic [DATA_W-1:0]          rec_data,
  output logic                       rec_corrupt,
  output logic                       rec_first,
  output logic                       rec_last,
  output logic [7:0]                 rec_beat,
  input  logic                       rec_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                drop_cnt
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int LOG_BB = $clog2(MASK_W);
  localparam int META_W = 3 + 3 + SIZE_W + 1 + ADDR_W + 1 + 1 + 1 + 8;

  logic [7:0]        beat_q;
  logic [8:0]        beats_q;
  logic [8:0]        calc_beats;
  logic [8:0]        cur_beats;
  logic              is_last;
  logic              fire;
  logic              pop;
  logic              push;
  logic              head_ld;
  logic              head_from_mem;
  logic [PW-1:0]     wptr_q;
  logic [PW-1:0]     rptr_q;
  logic [PW-1:0]     rptr_nxt;
  logic [LW-1:0]     level_q;
  logic [15:0]       drop_q;
  logic [META_W-1:0] mem_meta [DEPTH];
  logic [META_W-1:0] head_meta_q;
  logic [META_W-1:0] new_meta;

  // Burst length in beats, clamped to 256 so the 8-bit beat index wraps 255 -> 0 only on the last beat.
  always_comb begin
    calc_beats = 9'd1;
    if (a_opcode == 3'd0 || a_opcode == 3'd1) begin
      if (int'(a_size) >= LOG_BB + 8)
        calc_beats = 9'd256;
      else if (int'(a_size) > LOG_BB)
        calc_beats = 9'(1) << (int'(a_size) - LOG_BB);
    end
  end

  assign cur_beats     = (beat_q == 8'd0) ? calc_beats : beats_q;
  assign is_last       = ({1'b0, beat_q} == cur_beats - 9'd1);
  assign fire          = a_valid & a_ready;
  assign rec_valid     = (level_q != '0);
  assign pop           = rec_valid & rec_ready;
  assign push          = fire & ((level_q != LW'(DEPTH)) | pop);
  assign rptr_nxt      = rptr_q + PW'(1);
  assign head_from_mem = pop & (level_q > LW'(1));
  assign head_ld       = pop ? (head_from_mem | push) : ((level_q == '0) & push);
  assign new_meta      = {a_opcode, a_param, a_size, a_source, a_address, a_corrupt,
                          (beat_q == 8'd0), is_last, beat_q};

  always_ff @(posedge clock) begin
    if (push) mem_meta[wptr_q] <= new_meta;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q      <= '0;
      beats_q     <= 9'd1;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      head_meta_q <= '0;
    end else begin
      if (fire) begin
        if (beat_q == 8'd0) beats_q <= calc_beats;
        beat_q <= is_last ? 8'd0 : beat_q + 8'd1;
        if (!push && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop) rptr_q <= rptr_nxt;
      if (push && !pop) level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
      if (head_ld) head_meta_q <= head_from_mem ? mem_meta[rptr_nxt] : new_meta;
    end
  end

  assign {rec_opcode, rec_param, rec_size, rec_source, rec_address, rec_corrupt,
          rec_first, rec_last, rec_beat} = head_meta_q;
  assign level    = level_q;
  assign drop_cnt = drop_q;

`ifdef SIFIVE_INSIGHT_TL_A_DATA_CAPTURE_EN
  logic [MASK_W+DATA_W-1:0] mem_dat [DEPTH];
  logic [MASK_W+DATA_W-1:0] head_dat_q;

  always_ff @(posedge clock) begin
    if (push) mem_dat[wptr_q] <= {a_mask, a_data};
  end

  always_ff @(posedge clock) begin
    if (reset) head_dat_q <= '0;
    else if (head_ld) head_dat_q <= head_from_mem ? mem_dat[rptr_nxt] : {a_mask, a_data};
  end

  assign {rec_mask, rec_data} = head_dat_q;
`else
  logic unused_dat;
  assign unused_dat = ^{a_mask, a_data};
  assign rec_mask   = '0;
  assign rec_data   = '0;
`endif

endmodule
